imm_gen_pipe: RTL

- Parametrised, pipelined immediate generator for the RV32/RV64 decode stage.
- Extracts and extends the immediate of every base format (I, S, B, J, U) plus the CSR zero-extended uimm.
- Output is registered behind a valid/ready handshake with a 2-entry skid buffer, so decode back-pressure never creates a combinational ready path.
- Sits between instruction fetch/decode and the register-read/execute stage.

---
 rtl/imm_pkg.sv | 16 +
 rtl/imm_format_decode.sv | 39 +++
 rtl/imm_gen_pipe.sv | 86 ++++++++
 3 files changed

// File: rtl/imm_pkg.sv
// imm_pkg: shared immsrc encodings, occupancy states and XLEN check for the immediate generator
//   No ports; imported by imm_format_decode and imm_gen_pipe.
package imm_pkg;
    localparam logic [2:0] IMM_I   = 3'b000;
    localparam logic [2:0] IMM_S   = 3'b001;
    localparam logic [2:0] IMM_B   = 3'b010;
    localparam logic [2:0] IMM_J   = 3'b011;
    localparam logic [2:0] IMM_U   = 3'b100;
    localparam logic [2:0] IMM_CSR = 3'b101;

    typedef enum logic [1:0] {EMPTY, FULL1, FULL2} occ_t;

    function automatic bit xlen_legal(input int x);
        return x == 32 || x == 64;
    endfunction
endpackage

// File: rtl/imm_format_decode.sv
// imm_format_decode: combinational immediate extraction and extension for all base formats
//   instr   in  32    raw instruction word (bits [31:7] used)
//   immsrc  in  3     format select
//   imm     out XLEN  extended immediate, 0 when illegal
//   illegal out 1     reserved or disabled immsrc
module imm_format_decode
    import imm_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit EN_CSR_UIMM = 1'b1
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      immsrc,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);
    logic            s;
    logic            unused;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_c;

    assign s      = instr[31];
    assign unused = ^instr[6:0];
    assign imm_i  = {{(XLEN-11){s}}, instr[30:20]};
    assign imm_s  = {{(XLEN-11){s}}, instr[30:25], instr[11:7]};
    assign imm_b  = {{(XLEN-12){s}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j  = {{(XLEN-20){s}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_u  = {{(XLEN-31){s}}, instr[30:12], 12'b0};
    assign imm_c  = {{(XLEN-5){1'b0}}, instr[19:15]};

    always_comb begin
        illegal = immsrc > IMM_CSR || (immsrc == IMM_CSR && !EN_CSR_UIMM);
        imm     = illegal           ? '0    :
                  immsrc == IMM_I   ? imm_i :
                  immsrc == IMM_S   ? imm_s :
                  immsrc == IMM_B   ? imm_b :
                  immsrc == IMM_J   ? imm_j :
                  immsrc == IMM_U   ? imm_u : imm_c;
    end
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator behind a valid/ready 2-entry skid buffer
//   clk, rst_n         clock (rising) and async active-low reset
//   flush              sync kill of all held entries and of the current input
//   in_valid/in_ready  upstream handshake; in_ready depends on state only
//   instr, immsrc      instruction word and format select
//   out_valid/out_ready downstream handshake
//   imm_out, imm_illegal extended immediate and illegal-format flag of the head entry
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit EN_CSR_UIMM = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [2:0]      immsrc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm_out,
    output logic            imm_illegal
);
    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    occ_t            state, state_nx;
    logic [XLEN-1:0] dec_imm, m_imm, k_imm;
    logic            dec_ill, m_ill, k_ill;
    logic            push, pop, load_new;

    imm_format_decode #(.XLEN(XLEN), .EN_CSR_UIMM(EN_CSR_UIMM)) u_dec (
        .instr   (instr),
        .immsrc  (immsrc),
        .imm     (dec_imm),
        .illegal (dec_ill)
    );

    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    // M takes a fresh entry when empty or when its current entry leaves this cycle
    assign load_new = push && (state == EMPTY || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = flush           ? EMPTY :
                   state == EMPTY  ? (push ? FULL1 : EMPTY) :
                   state == FULL1  ? (push && !pop ? FULL2 : (pop && !push ? EMPTY : FULL1)) :
                                     (pop ? FULL1 : FULL2);
    end

    always_comb begin
        out_valid   = state != EMPTY;
        in_ready    = rst_n && state != FULL2;
        imm_out     = m_imm;
        imm_illegal = m_ill;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_imm <= '0;
            m_ill <= 1'b0;
            k_imm <= '0;
            k_ill <= 1'b0;
        end else if (!flush) begin
            if (load_new) begin
                m_imm <= dec_imm;
                m_ill <= dec_ill;
            end else if (state == FULL2 && pop) begin
                m_imm <= k_imm;
                m_ill <= k_ill;
            end
            if (state == FULL1 && push && !pop) begin
                k_imm <= dec_imm;
                k_ill <= dec_ill;
            end
        end
    end
endmodule
